// File: rtl/dot_accum_pkg.sv
// Shared constants, per-beat sideband flags and the width helper for the dot-product accumulator.
package dot_accum_pkg;

   localparam int unsigned DefaultLanes = 16;
   localparam int unsigned DefaultDw    = 8;
   localparam int unsigned DefaultAccw  = 32;

   typedef struct packed {
      logic valid;
      logic last;
      logic first;
   } beat_flags_t;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      while ((32'd1 << res) < value) begin
         res++;
      end
      return res;
   endfunction

endpackage

// File: rtl/dot_accum_tree.sv
// Pipelined pairwise adder tree: one register per level, each level one bit wider than the last.
// Operands are treated as two's complement; callers feed zero-topped values for unsigned data.
module dot_accum_tree
   import dot_accum_pkg::*;
#(
   parameter int unsigned LANES = DefaultLanes,
   parameter int unsigned IW    = 2 * DefaultDw
) (
   input  logic                       clk,
   input  logic [LANES*IW-1:0]        in_data,
   output logic [IW+clog2(LANES)-1:0] out_data
);

   localparam int unsigned Levels = clog2(LANES);

   for (genvar k = 0; k <= Levels; k++) begin : g_lvl
      localparam int unsigned N = LANES >> k;
      localparam int unsigned W = IW + k;

      logic [N*W-1:0] data;

      if (k == 0) begin : g_in
         assign data = in_data;
      end else begin : g_add
         logic [N*W-1:0] sum_d;
         logic [N*W-1:0] sum_q;

         always_comb begin
            sum_d = '0;
            for (int i = 0; i < int'(N); i++) begin
               sum_d[i*W +: W] =
                  {g_lvl[k-1].data[(2*i+1)*(W-1)-1], g_lvl[k-1].data[2*i*(W-1) +: W-1]} +
                  {g_lvl[k-1].data[(2*i+2)*(W-1)-1], g_lvl[k-1].data[(2*i+1)*(W-1) +: W-1]};
            end
         end

         always_ff @(posedge clk) begin
            sum_q <= sum_d;
         end

         assign data = sum_q;
      end
   end

   assign out_data = g_lvl[Levels].data;

endmodule

// File: rtl/dot_accum.sv
// Streaming dot-product accumulator: input register, lane products, adder tree, then a
// bias-seeded accumulator that emits one result per vector with overflow and beat count.
module dot_accum
   import dot_accum_pkg::*;
#(
   parameter int unsigned LANES  = DefaultLanes,
   parameter int unsigned DW     = DefaultDw,
   parameter int unsigned ACCW   = DefaultAccw,
   parameter bit          SIGNED = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic                  in_last,
   input  logic [LANES*DW-1:0]   pixels_in,
   input  logic [LANES*DW-1:0]   weights_in,
   input  logic [ACCW-1:0]       bias_in,
   output logic                  out_valid,
   output logic [ACCW-1:0]       sum_out,
   output logic                  ovf_out,
   output logic [15:0]           beats_out
);

   localparam int unsigned Log2L  = clog2(LANES);
   localparam int unsigned PW     = 2 * DW + 1;
   localparam int unsigned TRW    = PW + Log2L;
   localparam int unsigned Stages = Log2L + 2;
   localparam int unsigned AccSt  = Log2L + 1;

   logic                  first_q, first_d;
   beat_flags_t           flg_q  [Stages];
   beat_flags_t           flg_d  [Stages];
   logic [ACCW-1:0]       bias_q [Stages];
   logic [ACCW-1:0]       bias_d [Stages];
   logic [LANES*DW-1:0]   pix_q, pix_d, wt_q, wt_d;
   logic [LANES*PW-1:0]   prod_q, prod_d;
   logic [TRW-1:0]        tree_out;

   beat_flags_t           acc_flg;
   logic [ACCW-1:0]       addend, base;
   logic [ACCW:0]         acc_sum;
   logic                  add_ovf;
   logic [ACCW-1:0]       acc_q, acc_d;
   logic                  ovf_acc_q, ovf_acc_d;
   logic [15:0]           beat_cnt_q, beat_cnt_d;
   logic                  out_valid_q, out_valid_d;
   logic [ACCW-1:0]       sum_q, sum_d;
   logic                  ovf_out_q, ovf_out_d;
   logic [15:0]           beats_q, beats_d;

   // Product carries one guard bit so the tree can use signed adds for both operand modes.
   function automatic logic [PW-1:0] lane_product(input logic [DW-1:0] a,
                                                  input logic [DW-1:0] b);
      logic [PW-1:0] ax, bx;
      ax = SIGNED ? {{(DW+1){a[DW-1]}}, a} : {{(DW+1){1'b0}}, a};
      bx = SIGNED ? {{(DW+1){b[DW-1]}}, b} : {{(DW+1){1'b0}}, b};
      return ax * bx;
   endfunction

   always_comb begin
      first_d = first_q;
      if (in_valid) begin
         first_d = in_last;
      end
      flg_d[0]  = '{valid: in_valid, last: in_valid & in_last, first: first_q};
      bias_d[0] = (in_valid && first_q) ? bias_in : bias_q[0];
      pix_d     = pixels_in;
      wt_d      = weights_in;
      for (int s = 1; s < int'(Stages); s++) begin
         flg_d[s]  = flg_q[s-1];
         bias_d[s] = bias_q[s-1];
      end
   end

   always_comb begin
      prod_d = '0;
      for (int i = 0; i < int'(LANES); i++) begin
         prod_d[i*PW +: PW] = lane_product(pix_q[i*DW +: DW], wt_q[i*DW +: DW]);
      end
   end

   dot_accum_tree #(
      .LANES (LANES),
      .IW    (PW)
   ) u_tree (
      .clk      (clk),
      .in_data  (prod_q),
      .out_data (tree_out)
   );

   always_comb begin
      acc_flg = flg_q[AccSt];
      // The guard bit is zero for unsigned data, so sign-extension also zero-extends.
      addend  = ACCW'(signed'(tree_out));
      base    = acc_flg.first ? bias_q[AccSt] : acc_q;
      acc_sum = {1'b0, base} + {1'b0, addend};
      add_ovf = SIGNED ? ((base[ACCW-1] == addend[ACCW-1]) &&
                          (acc_sum[ACCW-1] != base[ACCW-1]))
                       : acc_sum[ACCW];

      acc_d      = acc_q;
      ovf_acc_d  = ovf_acc_q;
      beat_cnt_d = beat_cnt_q;
      if (acc_flg.valid) begin
         acc_d     = acc_sum[ACCW-1:0];
         ovf_acc_d = add_ovf | (~acc_flg.first & ovf_acc_q);
         if (acc_flg.first) begin
            beat_cnt_d = 16'd1;
         end else if (beat_cnt_q != 16'hFFFF) begin
            beat_cnt_d = beat_cnt_q + 16'd1;
         end
      end

      out_valid_d = acc_flg.valid & acc_flg.last;
      sum_d       = sum_q;
      ovf_out_d   = ovf_out_q;
      beats_d     = beats_q;
      if (out_valid_d) begin
         sum_d     = acc_d;
         ovf_out_d = ovf_acc_d;
         beats_d   = beat_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         first_q     <= 1'b1;
         for (int s = 0; s < int'(Stages); s++) begin
            flg_q[s] <= '0;
         end
         acc_q       <= '0;
         ovf_acc_q   <= 1'b0;
         beat_cnt_q  <= '0;
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         ovf_out_q   <= 1'b0;
         beats_q     <= '0;
      end else begin
         first_q     <= first_d;
         for (int s = 0; s < int'(Stages); s++) begin
            flg_q[s] <= flg_d[s];
         end
         acc_q       <= acc_d;
         ovf_acc_q   <= ovf_acc_d;
         beat_cnt_q  <= beat_cnt_d;
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
         ovf_out_q   <= ovf_out_d;
         beats_q     <= beats_d;
      end
   end

   // Datapath only matters when its valid flag is set, so it needs no reset.
   always_ff @(posedge clk) begin
      pix_q  <= pix_d;
      wt_q   <= wt_d;
      prod_q <= prod_d;
      for (int s = 0; s < int'(Stages); s++) begin
         bias_q[s] <= bias_d[s];
      end
   end

   assign out_valid = out_valid_q;
   assign sum_out   = sum_q;
   assign ovf_out   = ovf_out_q;
   assign beats_out = beats_q;

endmodule

// File: tb/tb_dot_accum.sv
// Drives three dot_accum configurations (unsigned/32, signed/32, unsigned/20) with shared
// stimulus and checks every result against an arithmetic reference model.
module tb_dot_accum;

   localparam int Lat = 6;

   typedef struct {
      longint cyc;
      longint sum;
      bit     ovf;
      int     beats;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_last = 1'b0;
   logic [127:0] pix = '0;
   logic [127:0] wt = '0;
   logic [31:0]  bias = '0;

   logic         v0, v1, v2, o0, o1, o2;
   logic [31:0]  s0, s1;
   logic [19:0]  s2;
   logic [15:0]  b0, b1, b2;

   int     n_checks = 0;
   int     n_fail = 0;
   longint cyc = 0;
   bit     in_rst = 1'b1;

   int     accw [3] = '{32, 32, 20};
   bit     sgn  [3] = '{1'b0, 1'b1, 1'b0};
   longint acc_m [3];
   bit     ovf_m [3];
   int     beats_m [3];
   bit     first_m [3];
   longint hsum [3];
   bit     hovf [3];
   int     hbeats [3];
   int     pulses [3] = '{0, 0, 0};
   exp_t   exp_q [3][$];

   dot_accum #(.LANES(16), .DW(8), .ACCW(32), .SIGNED(1'b0)) u_dut_u (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .pixels_in(pix),
      .weights_in(wt), .bias_in(bias), .out_valid(v0), .sum_out(s0), .ovf_out(o0),
      .beats_out(b0));

   dot_accum #(.LANES(16), .DW(8), .ACCW(32), .SIGNED(1'b1)) u_dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .pixels_in(pix),
      .weights_in(wt), .bias_in(bias), .out_valid(v1), .sum_out(s1), .ovf_out(o1),
      .beats_out(b1));

   dot_accum #(.LANES(16), .DW(8), .ACCW(20), .SIGNED(1'b0)) u_dut_n (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .pixels_in(pix),
      .weights_in(wt), .bias_in(bias[19:0]), .out_valid(v2), .sum_out(s2), .ovf_out(o2),
      .beats_out(b2));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic get_out(input int c, output bit v, output longint s, output bit o,
                          output int b);
      case (c)
         0: begin v = v0; s = longint'(s0); o = o0; b = int'(b0); end
         1: begin v = v1; s = longint'(s1); o = o1; b = int'(b1); end
         default: begin v = v2; s = longint'(s2); o = o2; b = int'(b2); end
      endcase
   endtask

   function automatic logic [127:0] splat(input logic [7:0] x);
      return {16{x}};
   endfunction

   function automatic longint mask(input int c);
      return (longint'(1) << accw[c]) - 1;
   endfunction

   function automatic longint interp(input longint pat, input int c);
      if (sgn[c] && pat[accw[c]-1]) return pat - (longint'(1) << accw[c]);
      return pat;
   endfunction

   function automatic longint dot(input logic [127:0] p, input logic [127:0] w, input bit sg);
      longint s;
      byte    pa, wa;
      s = 0;
      for (int i = 0; i < 16; i++) begin
         pa = p[i*8 +: 8];
         wa = w[i*8 +: 8];
         if (sg) s += longint'(pa) * longint'(wa);
         else    s += longint'(p[i*8 +: 8]) * longint'(w[i*8 +: 8]);
      end
      return s;
   endfunction

   // Exact-integer reference: true sum, then overflow = true sum outside the ACCW range.
   task automatic model_beat(input int c, input bit l, input logic [127:0] p,
                             input logic [127:0] w, input logic [31:0] b);
      longint base, t, lim;
      bit     ov;
      base = first_m[c] ? interp(longint'(b) & mask(c), c) : interp(acc_m[c], c);
      t = base + dot(p, w, sgn[c]);
      if (sgn[c]) begin
         lim = longint'(1) << (accw[c] - 1);
         ov  = (t >= lim) || (t < -lim);
      end else begin
         ov = t >= (longint'(1) << accw[c]);
      end
      acc_m[c]   = t & mask(c);
      ovf_m[c]   = first_m[c] ? ov : (ovf_m[c] | ov);
      beats_m[c] = first_m[c] ? 1 : ((beats_m[c] >= 65535) ? 65535 : beats_m[c] + 1);
      first_m[c] = l;
      if (l) exp_q[c].push_back('{cyc: cyc + 1 + Lat, sum: acc_m[c], ovf: ovf_m[c],
                                  beats: beats_m[c]});
   endtask

   task automatic monitor(input int c);
      bit     v, o;
      longint s;
      int     b;
      exp_t   e;
      get_out(c, v, s, o, b);
      if (v) begin
         pulses[c]++;
         if (exp_q[c].size() == 0) begin
            check($sformatf("c%0d_spurious_valid", c), longint'(v), 0);
         end else begin
            e = exp_q[c].pop_front();
            check($sformatf("c%0d_latency", c), cyc, e.cyc);
            check($sformatf("c%0d_sum", c), s, e.sum);
            check($sformatf("c%0d_ovf", c), longint'(o), longint'(e.ovf));
            check($sformatf("c%0d_beats", c), longint'(b), longint'(e.beats));
            hsum[c]   = e.sum;
            hovf[c]   = e.ovf;
            hbeats[c] = e.beats;
         end
      end else begin
         if (exp_q[c].size() > 0 && exp_q[c][0].cyc <= cyc) begin
            check($sformatf("c%0d_missing_valid", c), longint'(v), 1);
            void'(exp_q[c].pop_front());
         end
         check($sformatf("c%0d_hold_sum", c), s, hsum[c]);
         check($sformatf("c%0d_hold_ovf", c), longint'(o), longint'(hovf[c]));
         check($sformatf("c%0d_hold_beats", c), longint'(b), longint'(hbeats[c]));
      end
   endtask

   always @(negedge clk) begin
      if (!in_rst) begin
         for (int c = 0; c < 3; c++) monitor(c);
      end
   end

   task automatic beat(input bit v, input bit l, input logic [127:0] p, input logic [127:0] w,
                       input logic [31:0] b);
      in_valid = v;
      in_last  = l;
      pix      = p;
      wt       = w;
      bias     = b;
      if (v) begin
         for (int c = 0; c < 3; c++) model_beat(c, l, p, w, b);
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) beat(1'b0, 1'b0, {$urandom, $urandom, $urandom, $urandom}, '0, $urandom);
   endtask

   task automatic do_reset(input int n);
      bit     v, o;
      longint s;
      int     b;
      in_rst   = 1'b1;
      rst      = 1'b1;
      in_valid = 1'b1;
      in_last  = 1'b1;
      repeat (n) @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      for (int c = 0; c < 3; c++) begin
         exp_q[c].delete();
         first_m[c] = 1'b1;
         acc_m[c]   = 0;
         ovf_m[c]   = 1'b0;
         beats_m[c] = 0;
         hsum[c]    = 0;
         hovf[c]    = 1'b0;
         hbeats[c]  = 0;
         get_out(c, v, s, o, b);
         check($sformatf("c%0d_rst_valid", c), longint'(v), 0);
         check($sformatf("c%0d_rst_sum", c), s, 0);
         check($sformatf("c%0d_rst_ovf", c), longint'(o), 0);
         check($sformatf("c%0d_rst_beats", c), longint'(b), 0);
      end
      in_rst = 1'b0;
   endtask

   initial begin
      int p0;
      @(negedge clk);
      do_reset(3);

      // Single full-scale beat.
      beat(1'b1, 1'b1, splat(8'hFF), splat(8'hFF), 32'd0);
      idle(10);
      check("max_beat_sum", longint'(s0), 1040400);
      check("max_beat_ovf", longint'(o0), 0);
      check("max_beat_beats", longint'(b0), 1);

      // Three beats with a two-cycle gap before the last.
      p0 = pulses[0];
      beat(1'b1, 1'b0, splat(8'd1), splat(8'd2), 32'd5);
      beat(1'b1, 1'b0, splat(8'd1), splat(8'd2), 32'hDEAD);
      idle(2);
      beat(1'b1, 1'b1, splat(8'd1), splat(8'd2), 32'd77);
      idle(10);
      check("gap_pulses", longint'(pulses[0] - p0), 1);
      check("gap_sum", longint'(s0), 101);
      check("gap_beats", longint'(b0), 3);

      // Back-to-back single-beat vectors.
      beat(1'b1, 1'b1, splat(8'd1), splat(8'd1), 32'd0);
      beat(1'b1, 1'b1, splat(8'd2), splat(8'd3), 32'd10);
      idle(10);
      check("b2b_sum", longint'(s0), 106);
      check("b2b_beats", longint'(b0), 1);

      // Signed extremes with negative bias.
      beat(1'b1, 1'b1, splat(8'h80), splat(8'h7F), 32'hFFFF_FFFF);
      idle(10);
      check("signed_sum", longint'(s1), longint'(32'hFFFC_07FF));
      check("signed_ovf", longint'(o1), 0);

      // Narrow accumulator wrap on the bias add.
      beat(1'b1, 1'b1, splat(8'd1), splat(8'd1), 32'h000F_FFFF);
      idle(10);
      check("wrap_sum", longint'(s2), longint'(20'h0000F));
      check("wrap_ovf", longint'(o2), 1);

      // Abort a vector with reset, then a fresh single beat.
      p0 = pulses[0];
      beat(1'b1, 1'b0, splat(8'd1), splat(8'd1), 32'd0);
      beat(1'b1, 1'b0, splat(8'd1), splat(8'd1), 32'd0);
      do_reset(1);
      beat(1'b1, 1'b1, splat(8'd1), splat(8'd1), 32'd0);
      idle(10);
      check("abort_pulses", longint'(pulses[0] - p0), 1);
      check("abort_sum", longint'(s0), 16);
      check("abort_beats", longint'(b0), 1);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         beat($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
              {$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom}, $urandom);
      end
      beat(1'b1, 1'b1, {$urandom, $urandom, $urandom, $urandom},
           {$urandom, $urandom, $urandom, $urandom}, $urandom);
      idle(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
